window_cropper: RTL and testbench



---
 rtl/window_cropper.sv | 139 +++++++++++++
 tb/tb_window_cropper.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_cropper.sv
// window_cropper: crops an AXI4-Stream video stream to a latched window (left, width, top, height).
// Optional m_eof end-of-window pulse is built only when WINDOW_CROPPER_EOF_EN is defined.
module window_cropper #(
    parameter int C_HBITS       = 12,
    parameter int C_WBITS       = 12,
    parameter int C_PIXEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [C_WBITS-1:0]       s_left,
    input  logic [C_WBITS-1:0]       s_width,
    input  logic [C_HBITS-1:0]       s_top,
    input  logic [C_HBITS-1:0]       s_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
`ifdef WINDOW_CROPPER_EOF_EN
    ,
    output logic                     m_eof
`endif
);
    localparam logic [C_WBITS-1:0] X_ONE  = C_WBITS'(1);
    localparam logic [C_HBITS-1:0] Y_ONE  = C_HBITS'(1);
    localparam logic [C_WBITS:0]   XE_ONE = (C_WBITS+1)'(1);
    localparam logic [C_HBITS:0]   YE_ONE = (C_HBITS+1)'(1);

    logic [C_WBITS-1:0]       r_left, r_width, r_x;
    logic [C_HBITS-1:0]       r_top, r_height, r_y;
    logic                     r_sofp;
    logic                     r_valid, r_user, r_last;
    logic [C_PIXEL_WIDTH-1:0] r_data;

    logic                     w_fire, w_sof, w_in, w_last, w_sofp;
    logic [C_WBITS-1:0]       w_left, w_width, w_x;
    logic [C_HBITS-1:0]       w_top, w_height, w_y;
    logic [C_WBITS:0]         w_xend;
    logic [C_HBITS:0]         w_yend;

    assign s_axis_tready = !r_valid || m_axis_tready;
    assign w_fire        = s_axis_tvalid && s_axis_tready;
    assign w_sof         = w_fire && s_axis_tuser;
    assign m_axis_tvalid = r_valid;
    assign m_axis_tdata  = r_data;
    assign m_axis_tuser  = r_user;
    assign m_axis_tlast  = r_last;

    // The SOF beat sees the freshly presented window and position (0,0) instead of the stale registers.
    always_comb begin
        w_left   = w_sof ? s_left   : r_left;
        w_width  = w_sof ? s_width  : r_width;
        w_top    = w_sof ? s_top    : r_top;
        w_height = w_sof ? s_height : r_height;
        w_x      = w_sof ? '0 : r_x;
        w_y      = w_sof ? '0 : r_y;
        w_sofp   = w_sof || r_sofp;
        w_xend   = {1'b0, w_left} + {1'b0, w_width};
        w_yend   = {1'b0, w_top} + {1'b0, w_height};
        w_in     = (w_x >= w_left) && ({1'b0, w_x} < w_xend) &&
                   (w_y >= w_top)  && ({1'b0, w_y} < w_yend);
        w_last   = (({1'b0, w_x} + XE_ONE) == w_xend) || s_axis_tlast;
    end

    // Window is captured only on a consumed SOF beat; mid-frame changes wait for the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_left   <= '0;
            r_width  <= '0;
            r_top    <= '0;
            r_height <= '0;
        end else if (w_sof) begin
            r_left   <= s_left;
            r_width  <= s_width;
            r_top    <= s_top;
            r_height <= s_height;
        end
    end

    // Column/row position of the next input beat, saturating at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_fire) begin
            r_x <= s_axis_tlast ? '0 : ((&w_x) ? w_x : w_x + X_ONE);
            r_y <= s_axis_tlast ? ((&w_y) ? w_y : w_y + Y_ONE) : w_y;
        end
    end

    // Remember a frame start until the first in-window pixel carries it out as tuser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sofp <= 1'b0;
        end else if (w_fire) begin
            r_sofp <= w_sofp && !w_in;
        end
    end

    // Single output register; it only advances when empty or being drained.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_user  <= 1'b0;
            r_last  <= 1'b0;
        end else if (s_axis_tready) begin
            r_valid <= w_fire && w_in;
            if (w_fire && w_in) begin
                r_data <= s_axis_tdata;
                r_user <= w_sofp;
                r_last <= w_last;
            end
        end
    end

`ifdef WINDOW_CROPPER_EOF_EN
    logic r_last_row;
    logic w_last_row;

    assign w_last_row = ({1'b0, w_y} + YE_ONE) == w_yend;
    assign m_eof      = r_valid && m_axis_tready && r_last && r_last_row;

    // Tag the held output beat with whether it came from the window's final row.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_row <= 1'b0;
        end else if (s_axis_tready && w_fire && w_in) begin
            r_last_row <= w_last_row;
        end
    end
`endif

endmodule

// File: tb/tb_window_cropper.sv
// tb_window_cropper: randomized and directed checks of window_cropper against a queue-based frame model.
module tb_window_cropper;
    localparam int HB = 12;
    localparam int WB = 12;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [WB-1:0] s_left = '0, s_width = '0;
    logic [HB-1:0] s_top = '0, s_height = '0;
    logic          s_axis_tvalid = 1'b0;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tuser = 1'b0, s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          m_axis_tvalid;
    logic [PW-1:0] m_axis_tdata;
    logic          m_axis_tuser, m_axis_tlast;
    logic          m_axis_tready = 1'b1;
    logic          tb_eof;

    window_cropper #(.C_HBITS(HB), .C_WBITS(WB), .C_PIXEL_WIDTH(PW)) dut (
        .clk(clk), .resetn(resetn),
        .s_left(s_left), .s_width(s_width), .s_top(s_top), .s_height(s_height),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
`ifdef WINDOW_CROPPER_EOF_EN
        , .m_eof(tb_eof)
`endif
    );
`ifndef WINDOW_CROPPER_EOF_EN
    assign tb_eof = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct { int d; bit u; bit l; bit lr; bit e; } beat_t;
    beat_t exp_q[$];
    beat_t got[$];
    int total = 0, bad = 0;
    int ml = 0, mw = 0, mt = 0, mh = 0, mx = 0, my = 0;
    bit mp = 0;
    int rmode = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", n, a, e);
        end
    endtask

    // Frame-level model: position from beat/row counts, window taken at each SOF.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            ml = 0; mw = 0; mt = 0; mh = 0; mx = 0; my = 0; mp = 0;
        end else begin
            chk("tready", s_axis_tready, !m_axis_tvalid || m_axis_tready);
            chk("occupancy", m_axis_tvalid, exp_q.size());
            if (m_axis_tvalid && exp_q.size() > 0) begin
                chk("tdata", m_axis_tdata, exp_q[0].d[PW-1:0]);
                chk("tuser", m_axis_tuser, exp_q[0].u);
                chk("tlast", m_axis_tlast, exp_q[0].l);
            end
`ifdef WINDOW_CROPPER_EOF_EN
            chk("eof", tb_eof, m_axis_tvalid && m_axis_tready && exp_q.size() > 0 && exp_q[0].l && exp_q[0].lr);
`endif
            if (m_axis_tvalid && m_axis_tready) begin
                got.push_back('{d: m_axis_tdata, u: m_axis_tuser, l: m_axis_tlast, lr: 1'b0, e: tb_eof});
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (s_axis_tvalid && s_axis_tready) begin
                if (s_axis_tuser) begin
                    ml = s_left; mw = s_width; mt = s_top; mh = s_height;
                    mx = 0; my = 0; mp = 1;
                end
                if (mx >= ml && mx < ml + mw && my >= mt && my < mt + mh) begin
                    exp_q.push_back('{d: s_axis_tdata, u: mp, l: (mx == ml + mw - 1) || s_axis_tlast,
                                      lr: (my == mt + mh - 1), e: 1'b0});
                    mp = 0;
                end
                if (s_axis_tlast) begin
                    mx = 0; my++;
                end else begin
                    mx++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = $urandom_range(0, 3) != 0;
        endcase
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] d, input bit u, input bit l);
        bit f;
        int n = 0;
        s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tuser = u; s_axis_tlast = l;
        do begin
            @(negedge clk);
            f = s_axis_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!f && n < 1000);
        if (!f) begin
            total++; bad++;
            $display("FAIL accept: actual=stalled required=consumed");
            $fatal(1, "input never accepted");
        end
    endtask

    task automatic setwin(input int l, input int w, input int t, input int h);
        s_left = WB'(l); s_width = WB'(w); s_top = HB'(t); s_height = HB'(h);
    endtask

    task automatic frame(input int cols, input int rows, input int stop = -1, input int gap = 0,
                         input bit rnd = 0, input int chg_row = -1, input int chg_l = 0, input int chg_w = 0);
        int k = 0;
        for (int y = 0; y < rows; y++) begin
            for (int x = 0; x < cols; x++) begin
                if (stop >= 0 && k == stop) begin
                    s_axis_tvalid = 1'b0;
                    return;
                end
                if (y == chg_row && x == 0) begin
                    s_left = WB'(chg_l); s_width = WB'(chg_w);
                end
                if (gap > 0 && $urandom_range(0, 99) < gap) idle(1);
                send(rnd ? PW'($urandom) : PW'(16 * y + x), y == 0 && x == 0, x == cols - 1);
                k++;
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic pin_basic(input string n);
        int dv[6] = '{'h12, 'h13, 'h14, 'h22, 'h23, 'h24};
        chk({n, "_count"}, got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            chk({n, "_data"}, got[i].d, dv[i]);
            chk({n, "_user"}, got[i].u, i == 0);
            chk({n, "_last"}, got[i].l, i == 2 || i == 5);
`ifdef WINDOW_CROPPER_EOF_EN
            chk({n, "_eof"}, got[i].e, i == 5);
`endif
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_axis_tvalid, 0);
        chk("rst_data", m_axis_tdata, 0);
        chk("rst_user", m_axis_tuser, 0);
        chk("rst_last", m_axis_tlast, 0);
        chk("rst_ready", s_axis_tready, 1);
        resetn = 1'b1;
        idle(2);

        setwin(2, 3, 1, 2);
        for (int i = 0; i < 4; i++) send(PW'(i), 0, i == 3);
        idle(3);
        chk("pre_sof_count", got.size(), 0);

        got.delete();
        frame(8, 4);
        idle(4);
        pin_basic("basic");

        rmode = 1;
        got.delete();
        frame(8, 4);
        idle(6);
        pin_basic("bp");
        rmode = 0;
        idle(2);

        got.delete();
        frame(8, 4, -1, 0, 0, 2, 0, 1);
        idle(4);
        pin_basic("chg_old");
        got.delete();
        frame(8, 4);
        idle(4);
        chk("chg_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("chg_d0", got[0].d, 'h10);
            chk("chg_d1", got[1].d, 'h20);
            chk("chg_u0", got[0].u, 1);
            chk("chg_l0", got[0].l, 1);
            chk("chg_l1", got[1].l, 1);
        end

        setwin(6, 4, 0, 5);
        got.delete();
        frame(8, 4);
        idle(4);
        chk("clip_count", got.size(), 8);
        if (got.size() == 8) begin
            chk("clip_d7", got[7].d, 'h37);
            chk("clip_l7", got[7].l, 1);
            chk("clip_l6", got[6].l, 0);
            chk("clip_e7", got[7].e, 0);
        end

        setwin(1, 0, 0, 4);
        got.delete();
        frame(8, 4);
        idle(3);
        chk("zero_w_count", got.size(), 0);

        setwin(0, 8, 0, 4);
        frame(8, 4, 8 * 2 + 3);
        idle(3);
        got.delete();
        frame(8, 4);
        idle(3);
        chk("early_count", got.size(), 32);
        if (got.size() > 0) chk("early_user", got[0].u, 1);

        setwin(2, 3, 1, 2);
        frame(8, 4, 8 + 3);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", m_axis_tvalid, 0);
        chk("mid_rst_data", m_axis_tdata, 0);
        chk("mid_rst_last", m_axis_tlast, 0);
        idle(2);
        resetn = 1'b1;
        idle(1);
        got.delete();
        for (int i = 0; i < 8; i++) send(PW'(i), 0, i == 7);
        idle(3);
        chk("post_rst_drop", got.size(), 0);
        frame(8, 4);
        idle(4);
        pin_basic("post_rst");

        for (int f = 0; f < 25; f++) begin
            int cols = $urandom_range(1, 10);
            int rows = $urandom_range(1, 8);
            rmode = $urandom_range(0, 2);
            setwin($urandom_range(0, 11), $urandom_range(0, 8), $urandom_range(0, 9), $urandom_range(0, 6));
            frame(cols, rows, ($urandom_range(0, 4) == 0) ? $urandom_range(0, cols * rows - 1) : -1,
                  $urandom_range(0, 40), 1, $urandom_range(0, 3) == 0 ? $urandom_range(0, rows) : -1,
                  $urandom_range(0, 6), $urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        rmode = 0;
        idle(10);
        chk("final_queue", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
